return_stack: RTL and testbench

Hardware return-address stack for the CPU's CALL/RET path. On CALL, the control unit pushes the incremented program counter (current PC + 1) onto the stack. On RET, it pops that address back to load the PC. The block is the consumer of the PC incrementer's output and replaces a software stack for subroutine linkage. It holds up to DEPTH addresses and reports overflow and underflow as sticky error flags.

---
 rtl/return_stack.sv | 133 +++++++++++++
 tb/tb_return_stack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// rtl/return_stack.sv - hardware return-address stack for the CALL/RET path
//
// Holds up to DEPTH return addresses. A CALL pushes push_addr (PC+1), a RET
// pops the top. Overflow and underflow are reported as sticky flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over all inputs)
//   push       CALL strobe, stores push_addr as the new top
//   pop        RET strobe, discards the current top
//   push_addr  return address to store
//   clear_err  clears overflow/underflow (a same-cycle error event wins)
//   top_addr   registered top of stack, 0 when empty
//   count      registered number of valid entries, 0..DEPTH
//   empty      registered, count == 0
//   full       registered, count == DEPTH
//   overflow   sticky: a push was dropped because the stack was full
//   underflow  sticky: a pop was issued while the stack was empty
module return_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_addr,
    input  logic                         clear_err,
    output logic [WIDTH-1:0]             top_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] TWO     = CW'(2);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             is_empty;
    logic             is_full;
    logic             ovf_ev;
    logic             unf_ev;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    below_idx;

    always_comb begin
        mem_d     = mem_q;
        count_d   = count_q;
        top_d     = top_q;
        ovf_ev    = 1'b0;
        unf_ev    = 1'b0;
        is_empty  = (count_q == '0);
        is_full   = (count_q == DEPTH_C);
        // Only meaningful when the stack holds at least one / two entries.
        top_idx   = AW'(count_q - ONE);
        below_idx = AW'(count_q - TWO);

        if (push && pop) begin
            if (is_empty) begin
                // Pop on empty is an error, but the push still lands.
                unf_ev   = 1'b1;
                mem_d[0] = push_addr;
                count_d  = ONE;
            end else begin
                // Tail call: overwrite the top in place, never overflows.
                mem_d[top_idx] = push_addr;
            end
            top_d = push_addr;
        end else if (push) begin
            if (is_full) begin
                ovf_ev = 1'b1;
            end else begin
                mem_d[count_q[AW-1:0]] = push_addr;
                count_d                = count_q + ONE;
                top_d                  = push_addr;
            end
        end else if (pop) begin
            if (is_empty) begin
                unf_ev = 1'b1;
            end else begin
                count_d = count_q - ONE;
                // Never expose stale storage once the last entry is gone.
                top_d   = (count_q == ONE) ? '0 : mem_q[below_idx];
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        // Set beats clear when both happen in the same cycle.
        ovf_d   = (ovf_q & ~clear_err) | ovf_ev;
        unf_d   = (unf_q & ~clear_err) | unf_ev;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            count_q <= '0;
            top_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top_addr  = top_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - self-checking bench for return_stack
module tb_return_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] push_addr = '0;
    logic             clear_err = 1'b0;
    logic [WIDTH-1:0] top_addr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] stk [$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    logic             model_on = 1'b0;

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .clear_err(clear_err), .top_addr(top_addr), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model with the same inputs.
    task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] a,
                        input logic c, input logic r);
        logic ovf_ev, unf_ev;
        push = p; pop = o; push_addr = a; clear_err = c; rst = r;
        @(posedge clk);
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (r) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && o) begin
                if (stk.size() == 0) begin
                    unf_ev = 1'b1;
                    stk.push_back(a);
                end else begin
                    stk[stk.size()-1] = a;
                end
            end else if (p) begin
                if (stk.size() == DEPTH) ovf_ev = 1'b1;
                else stk.push_back(a);
            end else if (o) begin
                if (stk.size() == 0) unf_ev = 1'b1;
                else void'(stk.pop_back());
            end
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            m_ovf = m_ovf | ovf_ev;
            m_unf = m_unf | unf_ev;
        end
        model_on = 1'b1;
        #1;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0; rst = 1'b0; push_addr = '0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_top",   top_addr, (stk.size() == 0) ? 32'h0 : stk[stk.size()-1]);
            chk("m_count", 32'(count), 32'(stk.size()));
            chk("m_empty", 32'(empty), 32'(stk.size() == 0));
            chk("m_full",  32'(full), 32'(stk.size() == DEPTH));
            chk("m_ovf",   32'(overflow), 32'(m_ovf));
            chk("m_unf",   32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        // Reset state
        step(0, 0, 0, 0, 1);
        chk("rst_top", top_addr, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);

        // Three pushes then three pops
        step(1, 0, 32'h100, 0, 0); chk("p1_top", top_addr, 32'h100);
        step(1, 0, 32'h200, 0, 0); chk("p2_top", top_addr, 32'h200);
        step(1, 0, 32'h300, 0, 0); chk("p3_top", top_addr, 32'h300);
        chk("p3_count", 32'(count), 32'd3);
        step(0, 1, 0, 0, 0); chk("o1_top", top_addr, 32'h200);
        step(0, 1, 0, 0, 0); chk("o2_top", top_addr, 32'h100);
        step(0, 1, 0, 0, 0); chk("o3_top", top_addr, 32'h0);
        chk("o3_count", 32'(count), 32'd0);
        chk("o3_empty", 32'(empty), 32'd1);
        chk("o3_flags", {30'd0, overflow, underflow}, 32'd0);

        // Fill, overflow, LIFO drain
        for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h1000 + 32'(i) * 32'h10, 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_top", top_addr, 32'h1070);
        step(1, 0, 32'hDEAD, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_top", top_addr, 32'h1070);
        for (int i = DEPTH - 1; i >= 1; i--) begin
            step(0, 1, 0, 0, 0);
            chk("drain_top", top_addr, 32'h1000 + 32'(i - 1) * 32'h10);
        end
        step(0, 1, 0, 0, 0);
        chk("drain_last", top_addr, 32'h0);
        chk("drain_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Underflow, clear racing an error, clear alone
        step(0, 1, 0, 0, 0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_top", top_addr, 32'h0);
        step(0, 1, 0, 1, 0);
        chk("unf_set_wins", 32'(underflow), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("unf_cleared", 32'(underflow), 32'd0);

        // Tail call while full
        for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h2000 + 32'(i), 0, 0);
        step(1, 1, 32'h5555, 0, 0);
        chk("tc_count", 32'(count), 32'd8);
        chk("tc_top", top_addr, 32'h5555);
        chk("tc_ovf", 32'(overflow), 32'd0);
        step(0, 1, 0, 0, 0);
        chk("tc_pop_top", top_addr, 32'h2006);

        // Push+pop on empty
        step(0, 0, 0, 0, 1);
        step(1, 1, 32'h42, 0, 0);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_top", top_addr, 32'h42);
        chk("pp_empty_unf", 32'(underflow), 32'd1);
        step(0, 1, 0, 1, 0);
        chk("pp_empty_pop", top_addr, 32'h0);

        // Reset mid-operation ignores a concurrent push
        step(1, 0, 32'h10, 0, 0);
        step(1, 0, 32'h20, 0, 0);
        step(1, 0, 32'h30, 0, 1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_top", top_addr, 32'h0);
        chk("mid_rst_flags", {30'd0, overflow, underflow}, 32'd0);
        step(0, 1, 0, 0, 0);
        chk("mid_rst_unf", 32'(underflow), 32'd1);

        // Mixed back-to-back traffic, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
